multi_mode_counter: RTL and testbench
=====================================

MULTI_MODE_COUNTER -- requirements
Module: multi_mode_counter

Interface
REQ-001 Parameter WIDTH, default 5, counter width in bits; SHALL be >= 2.
REQ-002 Parameter MIN_VALUE, default 0, lower count bound; SHALL be < MAX_VALUE.
REQ-003 Parameter MAX_VALUE, default 16, upper count bound; SHALL be <= 2**WIDTH-1.
REQ-004 Parameter DIV, default 1, enabled cycles per counter step; SHALL be >= 1.
REQ-005 i_clk  input  1  clock; all state changes on its rising edge.
REQ-006 i_reset  input  1  reset, asynchronous, active-low.
REQ-007 i_pause  input  1  high freezes all state.
REQ-008 i_set  input  1  high loads i_load_data.
REQ-009 i_load_data  input  WIDTH  value loaded by i_set.
REQ-010 i_mode  input  2  step mode: 00 up, 01 down, 10 rotate left, 11 rotate right.
REQ-011 o_data  output  WIDTH  current count, registered.
REQ-012 o_wrap  output  1  one-cycle pulse on a bound wrap, registered.
REQ-013 o_at_max / o_at_min  output  1 each  o_data == MAX_VALUE / == MIN_VALUE, decoded from o_data.

Function
REQ-014 Per-edge priority SHALL be: reset > pause > set > step.
REQ-015 Pause: o_data and the prescaler hold; o_wrap SHALL be 0.
REQ-016 Set: o_data <= i_load_data as-is (no range clamp); prescaler <= 0; o_wrap <= 0.
REQ-017 Prescaler: internal counter 0..DIV-1, advances on each edge not reset, paused or set; a step occurs on the edge where it equals DIV-1, and it then returns to 0.
REQ-018 DIV=1: step on every enabled edge; prescaler logic may reduce to constant.
REQ-019 Non-step enabled edge: o_data holds; o_wrap <= 0.
REQ-020 Up step: o_data >= MAX_VALUE -> MIN_VALUE with o_wrap <= 1; else o_data+1, o_wrap <= 0.
REQ-021 Down step: o_data <= MIN_VALUE -> MAX_VALUE with o_wrap <= 1; else o_data-1, o_wrap <= 0.
REQ-022 Rotate left: o_data <= {o_data[WIDTH-2:0], o_data[WIDTH-1]}; o_wrap <= 0; bounds ignored.
REQ-023 Rotate right: o_data <= {o_data[0], o_data[WIDTH-1:1]}; o_wrap <= 0; bounds ignored.
REQ-024 Arithmetic SHALL be WIDTH bits, no overflow beyond bound checks (out-of-range values reach a bound via REQ-020/021).
REQ-025 i_mode is sampled only on step edges; a change between steps takes effect at the next step, prescaler unaffected.
REQ-026 o_wrap SHALL be high exactly the cycle o_data shows the wrapped value.
REQ-027 Set and pause asserted together: pause wins, load discarded.

Reset
REQ-028 i_reset low SHALL immediately force o_data = MIN_VALUE, o_wrap = 0, prescaler = 0, independent of i_clk.
REQ-029 Reset asserted mid-prescale or mid-rotate SHALL discard all progress; first step after release follows full DIV count.
REQ-030 After release, first state change SHALL occur on the first rising edge with i_reset high.

Verification (WIDTH=5, MIN=0, MAX=16 unless noted)
REQ-031 DIV=1, mode 00 from reset, 17 edges -> o_data 1..16 then 0; o_wrap high only with the 0; o_at_max high at 16.
REQ-032 DIV=1, mode 01 from reset -> o_data 16 with o_wrap=1 on first edge, then 15, 14.
REQ-033 DIV=1, set with i_load_data=5'b00011, then mode 10 for 5 edges -> 00110, 01100, 11000, 10001, 00011; mode 11 one edge from 00011 -> 10001; o_wrap stays 0.
REQ-034 DIV=3, mode 00 -> o_data changes every 3rd edge; pause 2 cycles mid-prescale -> step delayed exactly 2 edges.
REQ-035 Set 31 (above MAX), mode 00 step -> 0, o_wrap=1; set and pause together -> o_data unchanged.
REQ-036 Assert i_reset between edges at o_data=9 -> o_data=0 before next edge; release, DIV=3 -> first step on 3rd edge.

Source files
------------

// File: rtl/multi_mode_counter.sv
// Bounded up/down counter with rotate modes, a step prescaler, load and pause.
// Counter value, wrap pulse and bound flags are all registered.
module multi_mode_counter #(
    parameter int WIDTH     = 5,
    parameter int MIN_VALUE = 0,
    parameter int MAX_VALUE = 16,
    parameter int DIV       = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_pause,
    input  logic             i_set,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_data,
    output logic             o_wrap,
    output logic             o_at_max,
    output logic             o_at_min
);

    typedef enum logic [1:0] {
        MODE_UP  = 2'b00,
        MODE_DN  = 2'b01,
        MODE_ROL = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    localparam int               PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [WIDTH-1:0] MIN_W      = WIDTH'(MIN_VALUE);
    localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX_VALUE);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);

    logic [WIDTH-1:0] data_r;
    logic             wrap_r;
    logic             at_max_r;
    logic             at_min_r;
    logic [PW-1:0]    presc_r;

    logic [WIDTH-1:0] data_s;
    logic             wrap_s;
    logic [PW-1:0]    presc_s;
    logic             step_s;

    // Next-state selection: pause beats load, load beats a prescaled step.
    always_comb begin
        data_s  = data_r;
        wrap_s  = 1'b0;
        presc_s = presc_r;
        step_s  = 1'b0;
        if (i_pause) begin
            data_s  = data_r;
            presc_s = presc_r;
        end else if (i_set) begin
            data_s  = i_load_data;
            presc_s = {PW{1'b0}};
        end else begin
            if (presc_r == PRESC_LAST) begin
                step_s  = 1'b1;
                presc_s = {PW{1'b0}};
            end else begin
                step_s  = 1'b0;
                presc_s = presc_r + PW'(1);
            end
            // Out-of-range values fall into the wrap branch and land on a bound.
            if (step_s) begin
                case (mode_e'(i_mode))
                    MODE_UP: begin
                        if (data_r >= MAX_W) begin
                            data_s = MIN_W;
                            wrap_s = 1'b1;
                        end else begin
                            data_s = data_r + WIDTH'(1);
                        end
                    end
                    MODE_DN: begin
                        if (data_r <= MIN_W) begin
                            data_s = MAX_W;
                            wrap_s = 1'b1;
                        end else begin
                            data_s = data_r - WIDTH'(1);
                        end
                    end
                    MODE_ROL: data_s = {data_r[WIDTH-2:0], data_r[WIDTH-1]};
                    MODE_ROR: data_s = {data_r[0], data_r[WIDTH-1:1]};
                    default:  data_s = data_r;
                endcase
            end else begin
                data_s = data_r;
            end
        end
    end

    // State and output registers; bound flags are decoded from the next value
    // so they always line up with o_data.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            data_r   <= MIN_W;
            wrap_r   <= 1'b0;
            presc_r  <= {PW{1'b0}};
            at_max_r <= 1'b0;
            at_min_r <= 1'b1;
        end else begin
            data_r   <= data_s;
            wrap_r   <= wrap_s;
            presc_r  <= presc_s;
            at_max_r <= (data_s == MAX_W);
            at_min_r <= (data_s == MIN_W);
        end
    end

    assign o_data   = data_r;
    assign o_wrap   = wrap_r;
    assign o_at_max = at_max_r;
    assign o_at_min = at_min_r;

endmodule

// File: tb/tb_multi_mode_counter.sv
// Drives a DIV=1 and a DIV=3 counter with shared directed stimulus and checks
// both against an arithmetic model every cycle plus hand-computed values.
module tb_multi_mode_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pause;
    logic       set;
    logic [4:0] load;
    logic [1:0] mode;

    logic [4:0] d    [2];
    logic       w    [2];
    logic       amax [2];
    logic       amin [2];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    int m_val  [2];
    int m_cnt  [2];
    bit m_wrap [2];
    int mdiv   [2] = '{1, 3};

    multi_mode_counter #(.WIDTH(5), .MIN_VALUE(0), .MAX_VALUE(16), .DIV(1)) u_div1 (
        .i_clk(clk), .i_reset(rst_n), .i_pause(pause), .i_set(set),
        .i_load_data(load), .i_mode(mode),
        .o_data(d[0]), .o_wrap(w[0]), .o_at_max(amax[0]), .o_at_min(amin[0])
    );

    multi_mode_counter #(.WIDTH(5), .MIN_VALUE(0), .MAX_VALUE(16), .DIV(3)) u_div3 (
        .i_clk(clk), .i_reset(rst_n), .i_pause(pause), .i_set(set),
        .i_load_data(load), .i_mode(mode),
        .o_data(d[1]), .o_wrap(w[1]), .o_at_max(amax[1]), .o_at_min(amin[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // Counter rules in plain integer arithmetic: c counts enabled edges since the last step.
    function automatic void mstep(input int v0, input int c0, input int dv,
                                  input logic p, input logic s, input logic [4:0] ld,
                                  input logic [1:0] md,
                                  output int v, output int c, output bit wr);
        v  = v0;
        c  = c0;
        wr = 1'b0;
        if (!p) begin
            if (s) begin
                v = int'(ld);
                c = 0;
            end else begin
                c = c0 + 1;
                if (c == dv) begin
                    c = 0;
                    case (md)
                        2'd0: if (v0 >= 16) begin v = 0;  wr = 1'b1; end else v = v0 + 1;
                        2'd1: if (v0 <= 0)  begin v = 16; wr = 1'b1; end else v = v0 - 1;
                        2'd2: v = ((v0 << 1) | (v0 >> 4)) & 31;
                        default: v = (v0 >> 1) | ((v0 & 1) << 4);
                    endcase
                end
            end
        end
    endfunction

    // Reference model update.
    always @(posedge clk or negedge rst_n) begin
        int nv, nc;
        bit nw;
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                m_val[u]  <= 0;
                m_cnt[u]  <= 0;
                m_wrap[u] <= 1'b0;
            end else begin
                mstep(m_val[u], m_cnt[u], mdiv[u], pause, set, load, mode, nv, nc, nw);
                m_val[u]  <= nv;
                m_cnt[u]  <= nc;
                m_wrap[u] <= nw;
            end
        end
    end

    // Per-cycle comparison of both counters against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int u = 0; u < 2; u++) begin
                chk($sformatf("mdl_u%0d_data", u), 32'(d[u]), 32'(m_val[u]));
                chk($sformatf("mdl_u%0d_wrap", u), 32'(w[u]), 32'(m_wrap[u]));
                chk($sformatf("mdl_u%0d_at_max", u), 32'(amax[u]), 32'(m_val[u] == 16));
                chk($sformatf("mdl_u%0d_at_min", u), 32'(amin[u]), 32'(m_val[u] == 0));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Reset pulse placed between edges; outputs must clear before any edge.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_async_u1_data", 32'(d[0]), 32'd0);
        chk("rst_async_u3_data", 32'(d[1]), 32'd0);
        chk("rst_async_u1_wrap", 32'(w[0]), 32'd0);
        #1;
        rst_n = 1'b1;
    endtask

    logic [8:0] vt [18];
    int         rl [5];

    initial begin
        rst_n = 1'b0;
        pause = 1'b0;
        set   = 1'b0;
        load  = 5'd0;
        mode  = 2'b00;
        rl = '{6, 12, 24, 17, 3};
        vt = '{ {1'b0, 1'b0, 5'd0,  2'd0}, {1'b0, 1'b0, 5'd0, 2'd1}, {1'b0, 1'b0, 5'd0, 2'd1},
                {1'b1, 1'b0, 5'd0,  2'd1}, {1'b0, 1'b0, 5'd0, 2'd0}, {1'b0, 1'b1, 5'd20, 2'd0},
                {1'b0, 1'b0, 5'd0,  2'd0}, {1'b1, 1'b1, 5'd5, 2'd0}, {1'b0, 1'b0, 5'd0, 2'd3},
                {1'b0, 1'b0, 5'd0,  2'd2}, {1'b0, 1'b0, 5'd0, 2'd2}, {1'b0, 1'b0, 5'd0, 2'd1},
                {1'b0, 1'b0, 5'd0,  2'd1}, {1'b0, 1'b0, 5'd0, 2'd1}, {1'b0, 1'b1, 5'd0, 2'd1},
                {1'b0, 1'b0, 5'd0,  2'd1}, {1'b0, 1'b0, 5'd0, 2'd1}, {1'b0, 1'b0, 5'd0, 2'd1} };

        tick(1);
        cmp_en = 1'b1;
        chk("reset_u1_data", 32'(d[0]), 32'd0);
        chk("reset_u1_wrap", 32'(w[0]), 32'd0);
        chk("reset_u1_at_min", 32'(amin[0]), 32'd1);
        chk("reset_u1_at_max", 32'(amax[0]), 32'd0);
        chk("reset_u3_data", 32'(d[1]), 32'd0);
        rst_n = 1'b1;

        // Up count through MAX and the wrap to MIN.
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            chk("up_count", 32'(d[0]), 32'(k));
            chk("up_no_wrap", 32'(w[0]), 32'd0);
        end
        chk("up_at_max_16", 32'(amax[0]), 32'd1);
        tick(1);
        chk("up_wrap_value", 32'(d[0]), 32'd0);
        chk("up_wrap_pulse", 32'(w[0]), 32'd1);
        tick(1);
        chk("up_wrap_drop", 32'(w[0]), 32'd0);

        // Down count from reset wraps to MAX on the first edge.
        pulse_reset();
        mode = 2'b01;
        tick(1);
        chk("dn_first_value", 32'(d[0]), 32'd16);
        chk("dn_first_wrap", 32'(w[0]), 32'd1);
        tick(1);
        chk("dn_second", 32'(d[0]), 32'd15);
        chk("dn_second_wrap", 32'(w[0]), 32'd0);
        tick(1);
        chk("dn_third", 32'(d[0]), 32'd14);

        // Load, then rotate left five times and right once.
        set  = 1'b1;
        load = 5'b00011;
        tick(1);
        set = 1'b0;
        chk("load_3", 32'(d[0]), 32'd3);
        mode = 2'b10;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("rol_value", 32'(d[0]), 32'(rl[k]));
            chk("rol_no_wrap", 32'(w[0]), 32'd0);
        end
        mode = 2'b11;
        tick(1);
        chk("ror_value", 32'(d[0]), 32'd17);

        // DIV=3 stepping and a two-cycle pause mid-prescale.
        pulse_reset();
        mode = 2'b00;
        tick(2);
        chk("div3_before_step", 32'(d[1]), 32'd0);
        tick(1);
        chk("div3_first_step", 32'(d[1]), 32'd1);
        tick(1);
        chk("div3_mid", 32'(d[1]), 32'd1);
        pause = 1'b1;
        tick(2);
        chk("div3_paused", 32'(d[1]), 32'd1);
        chk("div3_paused_wrap", 32'(w[1]), 32'd0);
        pause = 1'b0;
        tick(1);
        chk("div3_delayed_hold", 32'(d[1]), 32'd1);
        tick(1);
        chk("div3_delayed_step", 32'(d[1]), 32'd2);

        // Above-range load wraps on an up step; set with pause is discarded.
        set  = 1'b1;
        load = 5'd31;
        tick(1);
        set = 1'b0;
        chk("load_31", 32'(d[0]), 32'd31);
        tick(1);
        chk("oor_wrap_value", 32'(d[0]), 32'd0);
        chk("oor_wrap_pulse", 32'(w[0]), 32'd1);
        set   = 1'b1;
        pause = 1'b1;
        load  = 5'd7;
        tick(1);
        chk("set_pause_hold", 32'(d[0]), 32'd0);
        chk("set_pause_wrap", 32'(w[0]), 32'd0);
        set   = 1'b0;
        pause = 1'b0;

        // Reset between edges at 9 with the DIV=3 counter mid-prescale.
        set  = 1'b1;
        load = 5'd8;
        tick(1);
        set = 1'b0;
        tick(1);
        chk("pre_rst_u1", 32'(d[0]), 32'd9);
        chk("pre_rst_u3", 32'(d[1]), 32'd8);
        pulse_reset();
        tick(2);
        chk("post_rst_u3_hold", 32'(d[1]), 32'd0);
        tick(1);
        chk("post_rst_u3_step", 32'(d[1]), 32'd1);

        // Mixed mode changes, loads and pauses, checked by the model.
        for (int i = 0; i < 18; i++) begin
            pause = vt[i][8];
            set   = vt[i][7];
            load  = vt[i][6:2];
            mode  = vt[i][1:0];
            tick(1);
        end
        pause = 1'b0;
        set   = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
